// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter: function codes and the
// arbiter sequencing states.
package alu_pkg;

    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first set request found
// searching upward from ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx
);

    // cand_idx[k] is the requester examined k-th, i.e. (ptr + k) mod NREQ.
    logic [IDXW-1:0] cand_idx [NREQ];
    logic            found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDXW:0] sum;
            assign sum = {1'b0, ptr} + (IDXW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDXW+1)'(NREQ)) ? IDXW'(sum - (IDXW+1)'(NREQ))
                                                           : sum[IDXW-1:0];
        end
    endgenerate

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[cand_idx[k]]) begin
                found              = 1'b1;
                gnt[cand_idx[k]]   = 1'b1;
                gnt_idx            = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters (IDLE -> ISSUE -> WAIT).
// Optional WAIT-state timeout is compiled in with ALU_ARB_TIMEOUT_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DWIDTH    = 16,
    parameter int NREQ      = 4
`ifdef ALU_ARB_TIMEOUT_EN
    ,
    parameter int TO_CYCLES = 8
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [3*NREQ-1:0]      req_func,
    input  logic [DWIDTH*NREQ-1:0] req_a,
    input  logic [DWIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DWIDTH-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   alu_en_in,
    output logic [2:0]             alu_func,
    output logic [DWIDTH-1:0]      alu_a,
    output logic [DWIDTH-1:0]      alu_b,
    input  logic [DWIDTH-1:0]      alu_res,
    input  logic                   alu_en_out
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_t      state_reg, state_next;
    logic [IDXW-1:0] rr_ptr_reg;
    logic [IDXW-1:0] owner_reg;
    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            handshake;
    logic            timeout;
    logic            wait_done;

    logic [2:0]        func_arr [NREQ];
    logic [DWIDTH-1:0] a_arr    [NREQ];
    logic [DWIDTH-1:0] b_arr    [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign func_arr[gi] = req_func[3*gi +: 3];
            assign a_arr[gi]    = req_a[DWIDTH*gi +: DWIDTH];
            assign b_arr[gi]    = req_b[DWIDTH*gi +: DWIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    logic [CW-1:0] to_cnt_reg;

    // Counts WAIT cycles; zero on the first WAIT cycle since it is held clear outside WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt_reg <= '0;
        else if (state_reg != WAIT)
            to_cnt_reg <= '0;
        else
            to_cnt_reg <= to_cnt_reg + CW'(1);
    end

    assign timeout = (state_reg == WAIT) && (to_cnt_reg == CW'(TO_CYCLES - 1));

    // A result arriving together with the timeout takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_err <= 1'b0;
        else if (state_reg == WAIT && wait_done)
            rsp_err <= !alu_en_out;
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign wait_done = alu_en_out | timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = gnt;
                handshake = |gnt;
                if (handshake)
                    state_next = ISSUE;
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            alu_en_in  <= 1'b0;
            alu_func   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= '0;
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        alu_func   <= func_arr[gnt_idx];
                        alu_a      <= a_arr[gnt_idx];
                        alu_b      <= b_arr[gnt_idx];
                        alu_en_in  <= 1'b1;
                        owner_reg  <= gnt_idx;
                        rr_ptr_reg <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
                    end
                end
                ISSUE: alu_en_in <= 1'b0;
                WAIT: begin
                    if (wait_done) begin
                        rsp_valid <= NREQ'(1) << owner_reg;
                        rsp_data  <= alu_en_out ? alu_res : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
